// File: rtl/sig_proc_pkg.sv
// Shared definitions for the signal-processing chain: default sample width
// and the level detector state encoding.
package sig_proc_pkg;

  localparam int unsigned SP_DATA_W = 8;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_ARM_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_ARM_LO = 2'd3
  } state_e;

endpackage

// File: rtl/consec_counter.sv
// Counts consecutive qualifying samples; done flags that the sample being
// counted now is the CONFIRM_N-th one. Shared by both arm states.
module consec_counter #(
  parameter int unsigned CONFIRM_N = 3
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int unsigned W = $clog2(CONFIRM_N + 1);
  localparam logic [W-1:0] LAST = W'(CONFIRM_N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/level_event_detector.sv
// Hysteresis comparator with N-sample debounce on the filtered sample stream;
// emits rise/fall pulses, debounced level, episode peak and event count.
module level_event_detector
  import sig_proc_pkg::*;
#(
  parameter int unsigned DATA_W    = SP_DATA_W,
  parameter int unsigned CONFIRM_N = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] Datain,
  input  logic              Enable,
  input  logic [DATA_W-1:0] Th_high,
  input  logic [DATA_W-1:0] Th_low,
  input  logic              Clear,
  output logic              Level,
  output logic              Rise,
  output logic              Fall,
  output logic [DATA_W-1:0] Peak,
  output logic              Peak_valid,
  output logic [CNT_W-1:0]  Event_count,
  output logic              Cfg_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] trk_q, trk_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]  ev_q, ev_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              pv_q, pv_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cnt_inc, cnt_clr, cnt_done;
  logic              above, below;
  logic [DATA_W-1:0] trk_max;

  consec_counter #(
    .CONFIRM_N(CONFIRM_N)
  ) u_cnt (
    .Clk    (Clk),
    .reset_n(reset_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .done   (cnt_done)
  );

  assign above   = (Datain > Th_high);
  assign below   = (Datain < Th_low);
  assign trk_max = (Datain > trk_q) ? Datain : trk_q;

  always_comb begin
    state_d   = state_q;
    trk_d     = trk_q;
    peak_d    = peak_q;
    ev_d      = ev_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    pv_d      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cfg_err_d = (Th_low >= Th_high);

    if (Clear) begin
      state_d = S_LOW;
      cnt_clr = 1'b1;
      trk_d   = '0;
      peak_d  = '0;
      ev_d    = '0;
    end else if (cfg_err_q) begin
      state_d = S_LOW;
      cnt_clr = 1'b1;
    end else if (Enable) begin
      // Counter reads 0 on entry to each arm run, so cnt_done alone decides
      // whether this sample completes the run (covers CONFIRM_N==1 too).
      unique case (state_q)
        S_LOW: begin
          if (above) begin
            trk_d = Datain;
            if (cnt_done) begin
              state_d = S_HIGH;
              cnt_clr = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = S_ARM_HI;
              cnt_inc = 1'b1;
            end
          end
        end
        S_ARM_HI: begin
          if (above) begin
            trk_d = trk_max;
            if (cnt_done) begin
              state_d = S_HIGH;
              cnt_clr = 1'b1;
              rise_d  = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            state_d = S_LOW;
            cnt_clr = 1'b1;
          end
        end
        S_HIGH, S_ARM_LO: begin
          trk_d = trk_max;
          if (below) begin
            if (cnt_done) begin
              state_d = S_LOW;
              cnt_clr = 1'b1;
              fall_d  = 1'b1;
              pv_d    = 1'b1;
              peak_d  = trk_max;
            end else begin
              state_d = S_ARM_LO;
              cnt_inc = 1'b1;
            end
          end else begin
            state_d = S_HIGH;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_clr = 1'b1;
        end
      endcase

      if (rise_d && (ev_q != '1)) begin
        ev_d = ev_q + 1'b1;
      end
    end

    level_d = (state_d == S_HIGH) || (state_d == S_ARM_LO);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_LOW;
      trk_q     <= '0;
      peak_q    <= '0;
      ev_q      <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pv_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      trk_q     <= trk_d;
      peak_q    <= peak_d;
      ev_q      <= ev_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pv_q      <= pv_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign Level       = level_q;
  assign Rise        = rise_q;
  assign Fall        = fall_q;
  assign Peak        = peak_q;
  assign Peak_valid  = pv_q;
  assign Event_count = ev_q;
  assign Cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_level_event_detector.sv
// Directed bench for level_event_detector: main instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=2) share one stimulus stream.
module tb_level_event_detector;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic [7:0] Datain;
  logic       Enable;
  logic [7:0] Th_high;
  logic [7:0] Th_low;
  logic       Clear;

  logic        Level, Rise, Fall, Peak_valid, Cfg_err;
  logic [7:0]  Peak;
  logic [15:0] Event_count;

  logic        Level2, Rise2, Fall2, Peak_valid2, Cfg_err2;
  logic [7:0]  Peak2;
  logic [1:0]  Event_count2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  level_event_detector #(
    .DATA_W(8), .CONFIRM_N(3), .CNT_W(16)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .Datain(Datain), .Enable(Enable),
    .Th_high(Th_high), .Th_low(Th_low), .Clear(Clear),
    .Level(Level), .Rise(Rise), .Fall(Fall), .Peak(Peak),
    .Peak_valid(Peak_valid), .Event_count(Event_count), .Cfg_err(Cfg_err)
  );

  level_event_detector #(
    .DATA_W(8), .CONFIRM_N(3), .CNT_W(2)
  ) dut2 (
    .Clk(Clk), .reset_n(reset_n), .Datain(Datain), .Enable(Enable),
    .Th_high(Th_high), .Th_low(Th_low), .Clear(Clear),
    .Level(Level2), .Rise(Rise2), .Fall(Fall2), .Peak(Peak2),
    .Peak_valid(Peak_valid2), .Event_count(Event_count2), .Cfg_err(Cfg_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [7:0] d);
    @(negedge Clk);
    Enable = 1'b1;
    Datain = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    @(negedge Clk);
    Enable = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    Datain  = '0;
    Enable  = 1'b0;
    Th_high = 8'd100;
    Th_low  = 8'd50;
    Clear   = 1'b0;

    // reset state
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_level", Level, 0);
    chk("rst_pulses", {Rise, Fall, Peak_valid}, 0);
    chk("rst_peak", Peak, 0);
    chk("rst_count", Event_count, 0);
    chk("rst_cfg", Cfg_err, 0);
    @(negedge Clk); reset_n = 1'b1;
    idle();
    chk("cfg_ok", Cfg_err, 0);

    // 1: basic rise
    sample(8'd120); chk("t1_rise_a", Rise, 0); chk("t1_level_a", Level, 0);
    sample(8'd130); chk("t1_rise_b", Rise, 0);
    sample(8'd140); chk("t1_rise", Rise, 1); chk("t1_level", Level, 1);
    chk("t1_count", Event_count, 1);
    idle();         chk("t1_rise_1cyc", Rise, 0); chk("t1_level_hold", Level, 1);

    // 3: fall run broken by equality, peak of episode
    sample(8'd120); sample(8'd200); sample(8'd150);
    sample(8'd40);  chk("t3_level_arm", Level, 1);
    sample(8'd50);  chk("t3_eq_nofall", Fall, 0);
    sample(8'd40);  sample(8'd30); chk("t3_nofall_2", Fall, 0);
    sample(8'd20);
    chk("t3_fall", Fall, 1); chk("t3_pv", Peak_valid, 1);
    chk("t3_peak", Peak, 200); chk("t3_level", Level, 0); chk("t3_rise", Rise, 0);
    idle();
    chk("t3_fall_1cyc", {Fall, Peak_valid}, 0); chk("t3_peak_hold", Peak, 200);

    // 2: broken rise runs, equality does not qualify
    sample(8'd120); sample(8'd120); sample(8'd90);
    sample(8'd120); sample(8'd100);
    chk("t2_norise", Rise, 0); chk("t2_count", Event_count, 1); chk("t2_level", Level, 0);
    sample(8'd120); chk("t2_back_low_a", Rise, 0);
    sample(8'd120); chk("t2_back_low_b", Rise, 0);
    sample(8'd120); chk("t2_rise", Rise, 1); chk("t2_count2", Event_count, 2);
    sample(8'd10); sample(8'd10); sample(8'd10);
    chk("t2_fall", Fall, 1); chk("t2_peak_new_episode", Peak, 120);

    // 4: idle gaps do not break a run, no pulses on idle cycles
    sample(8'd120);
    for (int i = 0; i < 4; i++) begin idle(); chk("t4_idle_rise", Rise, 0); end
    sample(8'd130);
    for (int i = 0; i < 2; i++) begin idle(); chk("t4_idle_rise2", Rise, 0); end
    sample(8'd140); chk("t4_rise", Rise, 1); chk("t4_count", Event_count, 3);
    idle(); chk("t4_idle_after", Rise, 0);
    sample(8'd10); idle(); chk("t4_idle_fall", Fall, 0);
    sample(8'd10); sample(8'd10);
    chk("t4_fall", Fall, 1); chk("t4_peak", Peak, 140);

    // 5: configuration error
    @(negedge Clk); Enable = 1'b0; Th_low = 8'd100;
    @(posedge Clk); #1;
    chk("t5_cfg_err", Cfg_err, 1);
    for (int i = 0; i < 5; i++) begin
      sample(8'd255); chk("t5_norise", Rise, 0); chk("t5_level", Level, 0);
    end
    chk("t5_count_hold", Event_count, 3);
    @(negedge Clk); Enable = 1'b0; Th_low = 8'd50;
    @(posedge Clk); #1;
    chk("t5_cfg_clr", Cfg_err, 0);
    sample(8'd120); sample(8'd130); sample(8'd140);
    chk("t5_rise", Rise, 1); chk("t5_count", Event_count, 4); chk("t5_peak_hold", Peak, 140);

    // 6: Clear while high
    @(negedge Clk); Enable = 1'b0; Clear = 1'b1;
    @(posedge Clk); #1;
    chk("t6_clr_level", Level, 0); chk("t6_clr_nofall", Fall, 0);
    chk("t6_clr_pv", Peak_valid, 0);
    chk("t6_clr_count", Event_count, 0); chk("t6_clr_peak", Peak, 0);
    @(negedge Clk); Clear = 1'b0;

    // 6: reset mid S_ARM_HI discards the episode
    sample(8'd120); sample(8'd130); sample(8'd140);
    sample(8'd10); sample(8'd10); sample(8'd10);
    chk("t6_pre_peak", Peak, 140); chk("t6_pre_count", Event_count, 1);
    sample(8'd120); sample(8'd130);
    @(negedge Clk); Enable = 1'b0; reset_n = 1'b0;
    #1;
    chk("t6_rst_count", Event_count, 0); chk("t6_rst_peak", Peak, 0);
    chk("t6_rst_level", Level, 0);
    @(negedge Clk); reset_n = 1'b1;
    sample(8'd140); chk("t6_rst_cnt_cleared", Rise, 0);
    sample(8'd10);  chk("t6_no_fall", Fall, 0);

    // 6: saturation on the narrow counter
    for (int k = 1; k <= 5; k++) begin
      sample(8'd120); sample(8'd130); sample(8'd140);
      chk("t6_sat_rise", Rise2, 1);
      chk("t6_sat_count", Event_count2, (k > 3) ? 3 : k);
      sample(8'd10); sample(8'd10); sample(8'd10);
    end
    chk("t6_wide_count", Event_count, 5);
    chk("t6_narrow_level", Level2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
